// File: rtl/ase_unshuffle_rob_pkg.sv
// ase_rob_pkg: shared defaults, pointer type and window check for the reorder buffer
package ase_rob_pkg;
  localparam int TAG_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  typedef logic [TAG_WIDTH_DEF:0] ptr_t;
  // tag is inside [head, tail) when its modulo distance from head is below the occupancy
  function automatic logic in_window(input logic [31:0] head, input logic [31:0] tail,
                                     input logic [31:0] tag, input int tw);
    logic [31:0] m;
    m = (32'd1 << tw) - 32'd1;
    return ((tag - head) & m) < ((tail - head) & ((m << 1) | 32'd1));
  endfunction
endpackage

// File: rtl/ase_unshuffle_rob_ram.sv
// rob_data_ram: DEPTH x DW simple dual-port RAM, sync write, registered read that holds when not enabled
//   clk; we/waddr/wdata write port; re/raddr read port; rdata registered read data
module rob_data_ram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ase_unshuffle_rob.sv
// ase_unshuffle_rob: reorder buffer allocating tags in order, accepting responses in any order, releasing in order
//   alloc_req/alloc_ready/alloc_tag: sequential tag allocation
//   wr_en/wr_tag/wr_data: out-of-order response writes (illegal ones set sticky err_bad_wr)
//   dout_valid/dout_ready/dout: in-order output stream; count: allocated, not yet drained entries
module ase_unshuffle_rob
  import ase_rob_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  wr_en,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [TAG_WIDTH:0]    count,
  output logic                  err_bad_wr
);
  localparam int DEPTH = 1 << TAG_WIDTH;
  logic [TAG_WIDTH:0] head, tail;
  logic [DEPTH-1:0] valid, set_mask, clr_mask;
  logic [TAG_WIDTH-1:0] head_idx;
  logic legal, wr_go, rd_issue;
  assign head_idx = head[TAG_WIDTH-1:0];
  assign count = tail - head;
  assign alloc_ready = !count[TAG_WIDTH];
  assign alloc_tag = tail[TAG_WIDTH-1:0];
  assign legal = in_window(32'(head), 32'(tail), 32'(wr_tag), TAG_WIDTH) && !valid[wr_tag];
  assign wr_go = wr_en && legal;
  assign rd_issue = valid[head_idx] && (!dout_valid || dout_ready);
  // a legal write needs valid==0 and an issue needs valid==1, so set and clear never collide
  assign set_mask = wr_go ? (DEPTH'(1) << wr_tag) : '0;
  assign clr_mask = rd_issue ? (DEPTH'(1) << head_idx) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      valid <= '0;
      dout_valid <= 1'b0;
      err_bad_wr <= 1'b0;
    end else begin
      if (alloc_req && alloc_ready) tail <= tail + 1'b1;
      if (rd_issue) head <= head + 1'b1;
      valid <= (valid | set_mask) & ~clr_mask;
      dout_valid <= rd_issue || (dout_valid && !dout_ready);
      if (wr_en && !legal) err_bad_wr <= 1'b1;
    end
  end
  rob_data_ram #(.AW(TAG_WIDTH), .DW(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_go),
    .waddr (wr_tag),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (head_idx),
    .rdata (dout)
  );
endmodule

// File: tb/tb_ase_unshuffle_rob.sv
// tb_ase_unshuffle_rob: directed and randomized checks of the reorder buffer against a queue-based model
module tb_ase_unshuffle_rob;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alloc_req = 1'b0;
  logic wr_en = 1'b0;
  logic dout_ready = 1'b0;
  logic [3:0] wr_tag = '0;
  logic [31:0] wr_data = '0;
  logic alloc_ready, dout_valid, err_bad_wr;
  logic [3:0] alloc_tag;
  logic [31:0] dout;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [3:0] tag; bit wr; logic [31:0] d;} ent_t;
  ent_t q[$];
  bit mdv = 0;
  bit merr = 0;
  logic [31:0] mdout = '0;
  logic [3:0] mt = '0;
  ase_unshuffle_rob dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .count(count),
    .err_bad_wr(err_bad_wr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic tick();
    int n;
    bit iss, found;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("alloc_ready", 64'(alloc_ready), 64'(n < 16));
    chk("alloc_tag", 64'(alloc_tag), 64'(mt));
    chk("dout_valid", 64'(dout_valid), 64'(mdv));
    if (mdv) chk("dout", 64'(dout), 64'(mdout));
    chk("err_bad_wr", 64'(err_bad_wr), 64'(merr));
    iss = n > 0 && q[0].wr && (!mdv || dout_ready);
    if (wr_en) begin
      found = 0;
      foreach (q[i]) if (q[i].tag == wr_tag && !q[i].wr) begin
        q[i].wr = 1;
        q[i].d = wr_data;
        found = 1;
      end
      if (!found) merr = 1;
    end
    if (iss) begin
      mdout = q[0].d;
      mdv = 1;
      void'(q.pop_front());
    end else if (dout_ready) mdv = 0;
    if (alloc_req && n < 16) begin
      q.push_back('{mt, 1'b0, 32'h0});
      mt++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    alloc_req = 0;
    wr_en = 0;
    #2;
    chk("rst_count", 64'(count), 0);
    chk("rst_alloc_ready", 64'(alloc_ready), 1);
    chk("rst_alloc_tag", 64'(alloc_tag), 0);
    chk("rst_dout_valid", 64'(dout_valid), 0);
    chk("rst_err", 64'(err_bad_wr), 0);
    q.delete();
    mdv = 0;
    mt = '0;
    merr = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic alloc_n(input int n);
    alloc_req = 1;
    repeat (n) tick();
    alloc_req = 0;
  endtask
  task automatic wr(input logic [3:0] t, input logic [31:0] d);
    wr_en = 1;
    wr_tag = t;
    wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic drain(input bit rnd);
    int k;
    k = 0;
    while ((q.size() != 0 || mdv) && k < 300) begin
      if (rnd) dout_ready = ($urandom % 3) != 0;
      tick();
      k++;
    end
    dout_ready = 1;
    if (k >= 300) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=idle", q.size());
    end
  endtask
  task automatic shuffle(output int p[16]);
    int j, t;
    for (int i = 0; i < 16; i++) p[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i];
      p[i] = p[j];
      p[j] = t;
    end
  endtask
  initial begin
    int p[16];
    int cand[$];
    #1;
    do_reset();
    dout_ready = 1;
    alloc_n(4);
    wr(4'd0, 32'hA0);
    chk("t1_lat_n1", 64'(dout_valid), 0);
    wr(4'd1, 32'hA1);
    chk("t1_lat_n2", 64'(dout_valid), 1);
    chk("t1_first", 64'(dout), 64'hA0);
    wr(4'd2, 32'hA2);
    wr(4'd3, 32'hA3);
    drain(0);
    do_reset();
    dout_ready = 1;
    alloc_n(4);
    for (int i = 3; i > 0; i--) begin
      wr(4'(i), 32'hB0 + 32'(i));
      chk("t2_hold", 64'(dout_valid), 0);
    end
    wr(4'd0, 32'hB0);
    chk("t2_wait", 64'(dout_valid), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t2_b2b_valid", 64'(dout_valid), 1);
      chk("t2_b2b_data", 64'(dout), 64'hB0 + 64'(k));
      tick();
    end
    chk("t2_end", 64'(dout_valid), 0);
    do_reset();
    dout_ready = 0;
    alloc_n(16);
    chk("t3_full_ready", 64'(alloc_ready), 0);
    chk("t3_full_count", 64'(count), 16);
    alloc_n(1);
    chk("t3_ignored", 64'(count), 16);
    shuffle(p);
    for (int i = 0; i < 16; i++) wr(4'(p[i]), 32'h300 + 32'(p[i]));
    tick();
    tick();
    chk("t3_free_ready", 64'(alloc_ready), 1);
    chk("t3_free_count", 64'(count), 15);
    chk("t3_next_tag", 64'(alloc_tag), 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_bp_valid", 64'(dout_valid), 1);
      chk("t4_bp_data", 64'(dout), 64'h300);
      tick();
    end
    dout_ready = 1;
    drain(0);
    for (int lap = 0; lap < 3; lap++) begin
      dout_ready = 0;
      alloc_n(16);
      shuffle(p);
      for (int i = 0; i < 16; i++) begin
        dout_ready = $urandom % 2;
        wr(4'(p[i]), $urandom);
      end
      drain(1);
    end
    for (int c = 0; c < 500; c++) begin
      alloc_req = $urandom % 2;
      dout_ready = ($urandom % 4) != 0;
      cand.delete();
      foreach (q[i]) if (!q[i].wr) cand.push_back(int'(q[i].tag));
      wr_en = cand.size() > 0 && ($urandom % 3) != 0;
      if (wr_en) begin
        wr_tag = 4'(cand[$urandom_range(0, cand.size() - 1)]);
        wr_data = $urandom;
      end
      tick();
    end
    alloc_req = 0;
    wr_en = 0;
    foreach (q[i]) if (!q[i].wr) begin
      wr(q[i].tag, $urandom);
    end
    drain(1);
    do_reset();
    dout_ready = 1;
    wr(4'd5, 32'h55);
    chk("t5_unalloc_err", 64'(err_bad_wr), 1);
    tick();
    tick();
    chk("t5_no_out", 64'(dout_valid), 0);
    do_reset();
    dout_ready = 1;
    alloc_n(1);
    wr(4'd0, 32'h11);
    wr(4'd0, 32'h22);
    chk("t5_dup_err", 64'(err_bad_wr), 1);
    chk("t5_dup_keep", 64'(dout), 64'h11);
    drain(0);
    do_reset();
    dout_ready = 0;
    alloc_n(6);
    wr(4'd1, 32'h61);
    wr(4'd3, 32'h63);
    chk("t6_outstanding", 64'(count), 6);
    do_reset();
    wr(4'd2, 32'h77);
    chk("t6_late_err", 64'(err_bad_wr), 1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
